// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared widths, Q4.12 helpers and sweep FSM states for the LIF scheduler
package lif_pkg;
    localparam int W  = 16;
    localparam int Q  = 12;
    localparam int SW = 2 * W + 2;

    typedef logic signed [W-1:0]  fx_t;
    typedef logic signed [SW-1:0] wide_t;

    localparam fx_t FX_MAX = {1'b0, {(W-1){1'b1}}};
    localparam fx_t FX_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} lif_state_t;

    // Constant Q4.12 from thousandths, rounded; intended for non-negative constants
    function automatic fx_t fx(input int milli);
        int r;
        r = (milli * (1 << Q) + 500) / 1000;
        return fx_t'(r);
    endfunction

    function automatic fx_t sat_fx(input wide_t x);
        if (x > wide_t'(FX_MAX))
            return FX_MAX;
        else if (x < wide_t'(FX_MIN))
            return FX_MIN;
        else
            return fx_t'(x);
    endfunction
endpackage

// File: rtl/lif_update_core.sv
// rtl/lif_update_core.sv - combinational leak/integrate/fire step for one neuron
module lif_update_core import lif_pkg::*; #(
    parameter int  RW         = 2,
    parameter fx_t V_TH       = fx(1000),
    parameter fx_t V_RESET    = fx(0),
    parameter fx_t V_REST     = fx(0),
    parameter fx_t LEAK_A     = fx(960),
    parameter int  REFR_TICKS = 2
) (
    input  logic signed [W-1:0] v,
    input  logic [RW-1:0]       refr,
    input  logic signed [W-1:0] i,
    output logic signed [W-1:0] v_next,
    output logic [RW-1:0]       refr_next,
    output logic                fire
);
    wide_t dv;
    wide_t prod;
    wide_t sum;
    fx_t   v_int;

    always_comb begin
        dv        = wide_t'(v) - wide_t'(V_REST);
        prod      = dv * wide_t'(LEAK_A);
        // arithmetic shift floors toward -inf, matching the leak definition
        sum       = wide_t'(V_REST) + (prod >>> Q) + wide_t'(i);
        v_int     = sat_fx(sum);
        fire      = 1'b0;
        v_next    = v_int;
        refr_next = refr;
        if (refr != '0) begin
            refr_next = refr - RW'(1);
            v_next    = V_RESET;
        end else if (v_int >= V_TH) begin
            fire      = 1'b1;
            v_next    = V_RESET;
            refr_next = RW'(REFR_TICKS);
        end
    end
endmodule

// File: rtl/lif_tdm_scheduler.sv
// rtl/lif_tdm_scheduler.sv - time-multiplexed LIF sweep with AER spike slot; LIF_PROBE_EN adds a v_mem probe port
module lif_tdm_scheduler import lif_pkg::*; #(
    parameter int  N_NEURONS  = 16,
    parameter int  IDX_W      = $clog2(N_NEURONS),
    parameter fx_t V_TH       = fx(1000),
    parameter fx_t V_RESET    = fx(0),
    parameter fx_t V_REST     = fx(0),
    parameter fx_t LEAK_A     = fx(960),
    parameter int  REFR_TICKS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_in,
    input  logic                i_wr_en,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic signed [W-1:0] i_wr_data,
    output logic                busy,
    output logic                done,
    output logic                tick_overrun,
    output logic                spk_valid,
    output logic [IDX_W-1:0]    spk_idx,
    input  logic                spk_ready
`ifdef LIF_PROBE_EN
    ,
    input  logic [IDX_W-1:0]    probe_idx,
    output logic signed [W-1:0] probe_vmem
`endif
);
    localparam int RW = (REFR_TICKS < 1) ? 1 : $clog2(REFR_TICKS + 1);

    lif_state_t          state;
    logic [IDX_W-1:0]    idx;
    fx_t                 v_mem [N_NEURONS];
    logic [RW-1:0]       refr  [N_NEURONS];
    fx_t                 acc   [N_NEURONS];

    fx_t                 v_nxt;
    logic [RW-1:0]       refr_nxt;
    logic                fire;
    logic                stall;
    logic                commit;
    logic                last;
    fx_t                 acc_add;

    lif_update_core #(
        .RW         (RW),
        .V_TH       (V_TH),
        .V_RESET    (V_RESET),
        .V_REST     (V_REST),
        .LEAK_A     (LEAK_A),
        .REFR_TICKS (REFR_TICKS)
    ) u_core (
        .v          (v_mem[idx]),
        .refr       (refr[idx]),
        .i          (acc[idx]),
        .v_next     (v_nxt),
        .refr_next  (refr_nxt),
        .fire       (fire)
    );

    // Only a firing neuron needs the slot, so only it can hold the sweep
    assign stall   = (state == SWEEP) && fire && spk_valid && !spk_ready;
    assign commit  = (state == SWEEP) && !stall;
    assign last    = (idx == IDX_W'(N_NEURONS - 1));
    assign acc_add = sat_fx(wide_t'(acc[i_wr_idx]) + wide_t'(i_wr_data));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            tick_overrun <= 1'b0;
            spk_valid    <= 1'b0;
            spk_idx      <= '0;
            for (int k = 0; k < N_NEURONS; k++) begin
                v_mem[k] <= V_REST;
                refr[k]  <= '0;
            end
        end else begin
            done <= 1'b0;
            if (tick_in && state != IDLE)
                tick_overrun <= 1'b1;
            if (spk_valid && spk_ready)
                spk_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick_in) begin
                        state <= SWEEP;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (commit) begin
                        v_mem[idx] <= v_nxt;
                        refr[idx]  <= refr_nxt;
                        if (fire) begin
                            spk_valid <= 1'b1;
                            spk_idx   <= idx;
                        end
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A write landing on the neuron being committed belongs to the next timestep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_NEURONS; k++)
                acc[k] <= '0;
        end else begin
            for (int k = 0; k < N_NEURONS; k++) begin
                if (commit && idx == IDX_W'(k))
                    acc[k] <= (i_wr_en && i_wr_idx == IDX_W'(k)) ? i_wr_data : '0;
                else if (i_wr_en && i_wr_idx == IDX_W'(k))
                    acc[k] <= acc_add;
            end
        end
    end

`ifdef LIF_PROBE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            probe_vmem <= '0;
        else
            probe_vmem <= v_mem[probe_idx];
    end
`endif
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// tb/tb_lif_tdm_scheduler.sv - randomized self-checking bench against a per-timestep neuron model
module tb_lif_tdm_scheduler;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_in = 1'b0;
    logic i_wr_en = 1'b0;
    logic [IW-1:0] i_wr_idx = '0;
    logic signed [15:0] i_wr_data = '0;
    logic spk_ready = 1'b0;
    logic busy, done, tick_overrun, spk_valid;
    logic [IW-1:0] spk_idx;

    always #5 clk = ~clk;

    lif_tdm_scheduler #(.N_NEURONS(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_in      (tick_in),
        .i_wr_en      (i_wr_en),
        .i_wr_idx     (i_wr_idx),
        .i_wr_data    (i_wr_data),
        .busy         (busy),
        .done         (done),
        .tick_overrun (tick_overrun),
        .spk_valid    (spk_valid),
        .spk_idx      (spk_idx),
        .spk_ready    (spk_ready)
    );

    int errors = 0;
    int checks = 0;
    int m_v [N];
    int m_r [N];
    int m_a [N];
    int exp_q [$];
    int got_q [$];
    int done_cnt = 0;
    bit rnd_ready = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_v[k] = 0;
            m_r[k] = 0;
            m_a[k] = 0;
        end
        exp_q.delete();
    endtask

    // One timestep: leak toward 0 by 0.96 (3932/4096, floored), add input, fire at 1.0
    task automatic model_step();
        int p;
        for (int k = 0; k < N; k++) begin
            if (m_r[k] > 0) begin
                m_r[k]--;
                m_v[k] = 0;
            end else begin
                p = sat16(((3932 * m_v[k]) >>> 12) + m_a[k]);
                if (p >= 4096) begin
                    exp_q.push_back(k);
                    m_v[k] = 0;
                    m_r[k] = 2;
                end else begin
                    m_v[k] = p;
                end
            end
            m_a[k] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (spk_valid && spk_ready) got_q.push_back(int'(spk_idx));
            if (done) done_cnt++;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rnd_ready) spk_ready = 1'($urandom_range(1));
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int k, input int d);
        i_wr_en   = 1'b1;
        i_wr_idx  = k[IW-1:0];
        i_wr_data = d[15:0];
        cyc(1);
        i_wr_en = 1'b0;
        m_a[k] = sat16(m_a[k] + d);
    endtask

    task automatic start_tick();
        model_step();
        got_q.delete();
        tick_in = 1'b1;
        cyc(1);
        tick_in = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            cyc(1);
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
    endtask

    task automatic compare_spikes(input string tag);
        int n = 0;
        while (spk_valid === 1'b1 && n < 100) begin
            cyc(1);
            n++;
        end
        cyc(1);
        check({tag, "_nspk"}, got_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
            check({tag, "_spk_idx"}, got_q[j], exp_q[j]);
        exp_q.delete();
    endtask

    task automatic run_tick(input string tag, input bit chk_lat);
        int n;
        start_tick();
        wait_done(tag, n);
        if (chk_lat) check({tag, "_latency"}, n + 1, N + 1);
        cyc(1);
        check({tag, "_done_pulse"}, done, 0);
        compare_spikes(tag);
    endtask

    initial begin
        int n;
        int dc;
        model_reset();
        cyc(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", tick_overrun, 0);
        check("rst_spk_valid", spk_valid, 0);
        check("rst_spk_idx", spk_idx, 0);
        rst_n = 1'b1;
        cyc(2);

        // Integrate 0.35/tick: fire on tick 3, refractory ticks 4-5
        spk_ready = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            wr(0, 1434);
            run_tick("dir", 1'b1);
            check("dir_fire_count", got_q.size(), (t == 3) ? 1 : 0);
        end

        // Slot full when neuron 2 fires: sweep holds until consumer is ready
        spk_ready = 1'b0;
        wr(1, 5000);
        wr(2, 5000);
        start_tick();
        cyc(8);
        check("stall_valid", spk_valid, 1);
        check("stall_idx", spk_idx, 1);
        check("stall_busy", busy, 1);
        check("stall_no_done", done_cnt > 0 && done, 0);
        spk_ready = 1'b1;
        cyc(1);
        check("stall_next_idx", spk_idx, 2);
        check("stall_next_valid", spk_valid, 1);
        wait_done("stall", n);
        check("stall_done_delay", n + 1, 2);
        compare_spikes("stall");

        // Two 7.9 writes saturate the accumulator and force a fire
        wr(3, 32358);
        wr(3, 32358);
        run_tick("sat", 1'b1);

        // Tick during sweep is ignored and latches overrun
        check("pre_overrun", tick_overrun, 0);
        dc = done_cnt;
        wr(0, 2000);
        start_tick();
        cyc(1);
        tick_in = 1'b1;
        cyc(1);
        tick_in = 1'b0;
        wait_done("ovr", n);
        cyc(20);
        check("ovr_flag", tick_overrun, 1);
        check("ovr_sweep_count", done_cnt - dc, 1);
        compare_spikes("ovr");

        // Random inputs with a randomly stalling consumer
        rnd_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            int nw;
            nw = int'($urandom_range(3));
            for (int w = 0; w < nw; w++)
                wr(int'($urandom_range(N - 1)), int'($urandom_range(12000)) - 6000);
            run_tick("rnd", 1'b0);
        end
        rnd_ready = 1'b0;
        cyc(2);
        spk_ready = 1'b1;

        // Reset mid-sweep: pending state must not survive
        wr(1, 4000);
        wr(3, 5000);
        start_tick();
        cyc(2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_overrun", tick_overrun, 0);
        check("mid_rst_spk_valid", spk_valid, 0);
        check("mid_rst_spk_idx", spk_idx, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        model_reset();
        wr(1, 1434);
        run_tick("post_rst", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
